alu_resp_checker: RTL and testbench
===================================

Name: alu_resp_checker

Overview:
- Synthesizable response checker for the 32-bit ALU datapath.
- Consumes the operand/result stream that a stimulus sequencer applies to the ALU: Ra, Rb, opcode and the ALU's Rz.
- Recomputes the golden result in a 2-stage pipeline, compares it against Rz, and keeps pass/fail statistics.
- Sits beside the ALU in self-checking benches and in the FPGA bring-up wrapper.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 16, width of the vector and error counters.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  synchronous, active-low reset.
- start  in  1  begin a checking session; clears statistics.
- vec_valid  in  1  Ra/Rb/op/Rz hold one vector this cycle.
- vec_last  in  1  end of stimulus; qualified with or without vec_valid.
- op  in  4  ALU opcode of the vector.
- Ra  in  WIDTH  operand A.
- Rb  in  WIDTH  operand B.
- Rz  in  WIDTH  result produced by the ALU under test.
- busy  out  1  session in progress (RUN or DRAIN).
- done  out  1  report valid.
- pass  out  1  done, no errors, and at least one vector checked.
- err_count  out  CNT_W  mismatching vectors, saturating.
- vec_count  out  CNT_W  vectors checked, saturating.
- first_err_idx  out  CNT_W  vec_count index of the first mismatch.
- first_err_exp  out  WIDTH  expected value at the first mismatch.
- first_err_got  out  WIDTH  Rz at the first mismatch.

Behaviour:
- Reset (clear=0 at posedge):
  - State goes to IDLE.
  - All outputs and pipeline valids go to 0.
  - Reset applies mid-session too; an in-flight vector is discarded.
- Opcodes and golden results (shift amount is Rb[4:0]):
  - 0 AND: Ra&Rb.
  - 1 OR: Ra|Rb.
  - 2 ADD: Ra+Rb mod 2^WIDTH.
  - 3 SUB: Ra-Rb mod 2^WIDTH.
  - 4 NOT: ~Ra.
  - 5 NEG: -Ra, two's complement.
  - 6 SHL: Ra<<Rb[4:0].
  - 7 SHR: logical Ra>>Rb[4:0].
  - 8 SHRA: arithmetic Ra>>>Rb[4:0].
  - 9 ROL: rotate Ra left by Rb[4:0].
  - 10 ROR: rotate Ra right by Rb[4:0].
  - 11-15 illegal: always counted as a mismatch; expected is reported as 0.
- FSM states: IDLE, RUN, DRAIN, REPORT.
  - IDLE: start -> RUN.
  - RUN: vec_last -> DRAIN.
  - DRAIN: exactly 2 cycles, then -> REPORT.
  - REPORT: start -> RUN.
- Entering RUN from start clears all counters, first_err_*, done and pass.
- start while in RUN or DRAIN restarts the session. Pipeline contents are flushed and not counted.
- Vectors are accepted only in RUN with vec_valid=1. vec_valid is ignored in IDLE, DRAIN and REPORT.
- vec_valid and vec_last in the same cycle: that vector is accepted and counted.
- Pipeline latency for a vector sampled at edge N:
  - Edge N+1: stage 1 registers the expected value and Rz.
  - Edge N+2: stage 2 compares and updates vec_count (+1) and err_count (+1 on mismatch).
- first_err_* are written only when err_count is 0 before that update. They hold until the next start.
- Counters saturate at 2^CNT_W-1.
- first_err_idx holds the pre-increment vec_count of the failing vector (0-based).
- Outputs in REPORT:
  - done=1.
  - pass = (err_count==0) && (vec_count!=0).
  - busy=0.
- busy=1 exactly in RUN and DRAIN.
- The checker is always ready; there is no backpressure.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_AND..OP_ROR.
  - Checker state encoding.
  - WIDTH default.
- One sub-module, alu_golden_model: combinational (op, Ra, Rb) -> expected, illegal.
  - Reusable by other benches.
- The checker holds the FSM, the pipeline registers and the statistics.

Test Plan:
- Reset, then start. Send 5 AND vectors:
  - (0,0)->0.
  - (ffffffff,ffffffff)->ffffffff.
  - (0,ffffffff)->0.
  - (ffffffff,ffff0000)->ffff0000.
  - (ffffffff,0000ffff)->0000ffff.
  - Then vec_last.
  - Required: done 4 cycles after the last vector's sample edge (2 DRAIN + REPORT entry); vec_count=5, err_count=0, pass=1.
- AND vectors with the third vector's Rz wrong (00000001 instead of 0):
  - err_count=1, first_err_idx=2, first_err_exp=0, first_err_got=00000001, pass=0.
- Arithmetic, shift and illegal ops:
  - ADD ffffffff+1 gives 0.
  - SHRA 80000000 by 4 gives f8000000.
  - ROR 00000001 by 1 gives 80000000.
  - Each with correct Rz: no errors.
  - Then op=13 with any Rz: err_count=1, first_err_exp=0.
- start then vec_last alone (no vectors):
  - REPORT with vec_count=0, pass=0.
- Disruptions mid-session:
  - clear=0 for one cycle two vectors into a session: all outputs 0, state IDLE.
  - start asserted during DRAIN: counters cleared, busy=1, and the in-flight vector is not counted.
- Saturation with CNT_W=3:
  - 9 failing vectors: err_count=7, vec_count=7, first_err_idx=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU checking slice: opcodes, checker state
// encoding and default datapath widths.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int CHK_CNT_W = 16;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_NEG  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_SHRA = 4'd8;
    localparam logic [3:0] OP_ROL  = 4'd9;
    localparam logic [3:0] OP_ROR  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } chk_state_e;

endpackage

// File: rtl/alu_resp_checker_if.sv
// Stimulus/response bundle between the ALU sequencer (master) and the
// response checker (slave).
interface alu_resp_checker_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = CHK_CNT_W
);
    logic             start;
    logic             vec_valid;
    logic             vec_last;
    logic [3:0]       op;
    logic [WIDTH-1:0] Ra;
    logic [WIDTH-1:0] Rb;
    logic [WIDTH-1:0] Rz;

    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] vec_count;
    logic [CNT_W-1:0] first_err_idx;
    logic [WIDTH-1:0] first_err_exp;
    logic [WIDTH-1:0] first_err_got;

    modport master (
        output start, vec_valid, vec_last, op, Ra, Rb, Rz,
        input  busy, done, pass, err_count, vec_count,
               first_err_idx, first_err_exp, first_err_got
    );

    modport slave (
        input  start, vec_valid, vec_last, op, Ra, Rb, Rz,
        output busy, done, pass, err_count, vec_count,
               first_err_idx, first_err_exp, first_err_got
    );
endinterface

// File: rtl/alu_golden_model.sv
// Combinational reference ALU: (op, Ra, Rb) -> expected result plus an
// illegal-opcode flag. Shift and rotate amounts come from the low bits of Rb.
module alu_golden_model
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
)
(
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] ra_i,
    input  logic [WIDTH-1:0] rb_i,
    output logic [WIDTH-1:0] expected_o,
    output logic             illegal_o
);
    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0] shamt_s;
    logic [SH_W:0]   shinv_s;

    assign shamt_s = rb_i[SH_W-1:0];
    // A zero rotate needs a full-width complementary shift, which yields 0.
    assign shinv_s = (SH_W+1)'(WIDTH) - {1'b0, shamt_s};

    // Opcode decode and golden result selection
    always_comb begin
        expected_o = '0;
        illegal_o  = 1'b0;
        case (op_i)
            OP_AND:  expected_o = ra_i & rb_i;
            OP_OR:   expected_o = ra_i | rb_i;
            OP_ADD:  expected_o = ra_i + rb_i;
            OP_SUB:  expected_o = ra_i - rb_i;
            OP_NOT:  expected_o = ~ra_i;
            OP_NEG:  expected_o = ~ra_i + WIDTH'(1);
            OP_SHL:  expected_o = ra_i << shamt_s;
            OP_SHR:  expected_o = ra_i >> shamt_s;
            OP_SHRA: expected_o = $unsigned($signed(ra_i) >>> shamt_s);
            OP_ROL:  expected_o = (ra_i << shamt_s) | (ra_i >> shinv_s);
            OP_ROR:  expected_o = (ra_i >> shamt_s) | (ra_i << shinv_s);
            default: begin
                expected_o = '0;
                illegal_o  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_resp_checker.sv
// Response checker for the ALU datapath: captures each vector, recomputes the
// golden result, compares it with Rz two edges later and keeps session stats.
module alu_resp_checker
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = CHK_CNT_W
)
(
    input  logic               clock,
    input  logic               clear,
    alu_resp_checker_if.slave  bus
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    chk_state_e       state_q, state_d;
    logic             drain_cnt_q, drain_cnt_d;

    logic             in_vld_q;
    logic             in_last_q;
    logic [3:0]       in_op_q;
    logic [WIDTH-1:0] in_ra_q;
    logic [WIDTH-1:0] in_rb_q;
    logic [WIDTH-1:0] in_rz_q;

    logic             s1_vld_q;
    logic             s1_ill_q;
    logic [WIDTH-1:0] s1_exp_q;
    logic [WIDTH-1:0] s1_got_q;

    logic [CNT_W-1:0] vec_count_q;
    logic [CNT_W-1:0] err_count_q;
    logic [CNT_W-1:0] first_idx_q;
    logic [WIDTH-1:0] first_exp_q;
    logic [WIDTH-1:0] first_got_q;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             accept_s;
    logic             last_s;
    logic             mismatch_s;
    logic [WIDTH-1:0] gold_exp_s;
    logic             gold_ill_s;

    // Once end of stimulus has been captured, nothing more enters the pipe.
    assign accept_s   = (state_q == ST_RUN) && bus.vec_valid && !in_last_q && !bus.start;
    assign last_s     = (state_q == ST_RUN) && bus.vec_last  && !in_last_q && !bus.start;
    assign mismatch_s = s1_ill_q || (s1_exp_q != s1_got_q);

    alu_golden_model #(.WIDTH(WIDTH)) u_golden (
        .op_i       (in_op_q),
        .ra_i       (in_ra_q),
        .rb_i       (in_rb_q),
        .expected_o (gold_exp_s),
        .illegal_o  (gold_ill_s)
    );

    // Session FSM next-state; start from any state (re)opens a session
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        if (bus.start) begin
            state_d     = ST_RUN;
            drain_cnt_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN: begin
                    if (in_last_q) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q) begin
                        state_d = ST_REPORT;
                    end else begin
                        drain_cnt_d = 1'b1;
                    end
                end
                ST_REPORT: state_d = ST_REPORT;
                default: begin
                    state_d     = ST_IDLE;
                    drain_cnt_d = 1'b0;
                end
            endcase
        end
    end

    // Report flags; done rises one cycle into REPORT so pass sees settled counters
    always_comb begin
        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_q == ST_REPORT) && !bus.start;
        pass_d = done_d && (err_count_q == '0) && (vec_count_q != '0);
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Input capture of one accepted vector and the end-of-stimulus marker
    always_ff @(posedge clock) begin
        if (!clear) begin
            in_vld_q  <= 1'b0;
            in_last_q <= 1'b0;
            in_op_q   <= 4'd0;
            in_ra_q   <= '0;
            in_rb_q   <= '0;
            in_rz_q   <= '0;
        end else begin
            in_vld_q  <= accept_s;
            in_last_q <= last_s;
            if (accept_s) begin
                in_op_q <= bus.op;
                in_ra_q <= bus.Ra;
                in_rb_q <= bus.Rb;
                in_rz_q <= bus.Rz;
            end
        end
    end

    // Stage 1: register golden result alongside the DUT response
    always_ff @(posedge clock) begin
        if (!clear) begin
            s1_vld_q <= 1'b0;
            s1_ill_q <= 1'b0;
            s1_exp_q <= '0;
            s1_got_q <= '0;
        end else begin
            s1_vld_q <= in_vld_q && !bus.start;
            if (in_vld_q) begin
                s1_ill_q <= gold_ill_s;
                s1_exp_q <= gold_exp_s;
                s1_got_q <= in_rz_q;
            end
        end
    end

    // Stage 2: compare and update statistics; a restart discards stage 1
    always_ff @(posedge clock) begin
        if (!clear) begin
            vec_count_q <= '0;
            err_count_q <= '0;
            first_idx_q <= '0;
            first_exp_q <= '0;
            first_got_q <= '0;
        end else if (bus.start) begin
            vec_count_q <= '0;
            err_count_q <= '0;
            first_idx_q <= '0;
            first_exp_q <= '0;
            first_got_q <= '0;
        end else if (s1_vld_q) begin
            vec_count_q <= sat_inc(vec_count_q);
            if (mismatch_s) begin
                err_count_q <= sat_inc(err_count_q);
                if (err_count_q == '0) begin
                    first_idx_q <= vec_count_q;
                    first_exp_q <= s1_exp_q;
                    first_got_q <= s1_got_q;
                end
            end
        end
    end

    // Registered status outputs
    always_ff @(posedge clock) begin
        if (!clear) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.err_count     = err_count_q;
    assign bus.vec_count     = vec_count_q;
    assign bus.first_err_idx = first_idx_q;
    assign bus.first_err_exp = first_exp_q;
    assign bus.first_err_got = first_got_q;

endmodule

// File: tb/tb_alu_resp_checker.sv
// Directed bench for alu_resp_checker: one task per scenario, inline checks.
module tb_alu_resp_checker;
    import alu_pkg::*;

    logic clock = 1'b0;
    logic clear;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;

    alu_resp_checker_if #(.WIDTH(32), .CNT_W(16)) if_a ();
    alu_resp_checker_if #(.WIDTH(32), .CNT_W(3))  if_s ();

    alu_resp_checker #(.WIDTH(32), .CNT_W(16)) dut (
        .clock (clock), .clear (clear), .bus (if_a.slave));
    alu_resp_checker #(.WIDTH(32), .CNT_W(3)) dut_sat (
        .clock (clock), .clear (clear), .bus (if_s.slave));

    task automatic idle_all();
        if_a.start = 1'b0; if_a.vec_valid = 1'b0; if_a.vec_last = 1'b0;
        if_a.op = 4'd0; if_a.Ra = 32'd0; if_a.Rb = 32'd0; if_a.Rz = 32'd0;
        if_s.start = 1'b0; if_s.vec_valid = 1'b0; if_s.vec_last = 1'b0;
        if_s.op = 4'd0; if_s.Ra = 32'd0; if_s.Rb = 32'd0; if_s.Rz = 32'd0;
    endtask

    task automatic start_a();
        if_a.start = 1'b1;
        @(negedge clock);
        if_a.start = 1'b0;
    endtask

    task automatic send_a(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] z, input logic last);
        if_a.op = op; if_a.Ra = a; if_a.Rb = b; if_a.Rz = z;
        if_a.vec_valid = 1'b1; if_a.vec_last = last;
        @(negedge clock);
        if_a.vec_valid = 1'b0; if_a.vec_last = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        repeat (2) @(negedge clock);
        n_tests++;
        if ({if_a.busy, if_a.done, if_a.pass, if_a.err_count, if_a.vec_count, if_a.first_err_idx,
             if_a.first_err_exp, if_a.first_err_got} !== 115'd0) begin
            n_fail++; $display("FAIL reset_outputs got busy=%b done=%b err=%0d vec=%0d want all 0",
                               if_a.busy, if_a.done, if_a.err_count, if_a.vec_count);
        end
        n_tests++;
        if ({if_s.busy, if_s.done, if_s.pass, if_s.err_count, if_s.vec_count} !== 9'd0) begin
            n_fail++; $display("FAIL reset_sat got err=%0d vec=%0d want 0", if_s.err_count, if_s.vec_count);
        end
        clear = 1'b1;
        @(negedge clock);
        n_tests++;
        if ({if_a.busy, if_a.done} !== 2'b00) begin
            n_fail++; $display("FAIL reset_idle got busy=%b done=%b want 0 0", if_a.busy, if_a.done);
        end
    endtask

    task automatic test_and_pass();
        logic [31:0] av [5] = '{32'h0, 32'hffffffff, 32'h0, 32'hffffffff, 32'hffffffff};
        logic [31:0] bv [5] = '{32'h0, 32'hffffffff, 32'hffffffff, 32'hffff0000, 32'h0000ffff};
        logic [31:0] zv [5] = '{32'h0, 32'hffffffff, 32'h0, 32'hffff0000, 32'h0000ffff};
        start_a();
        n_tests++;
        if ({if_a.busy, if_a.done} !== 2'b10) begin
            n_fail++; $display("FAIL and_busy got busy=%b done=%b want 1 0", if_a.busy, if_a.done);
        end
        for (int i = 0; i < 5; i++) send_a(OP_AND, av[i], bv[i], zv[i], (i == 4));
        repeat (3) @(negedge clock);
        n_tests++;
        if ({if_a.busy, if_a.done} !== 2'b00) begin
            n_fail++; $display("FAIL and_latency3 got busy=%b done=%b want 0 0", if_a.busy, if_a.done);
        end
        @(negedge clock);
        n_tests++;
        if ({if_a.done, if_a.pass, if_a.busy, if_a.vec_count, if_a.err_count} !== {3'b110, 16'd5, 16'd0}) begin
            n_fail++; $display("FAIL and_report got done=%b pass=%b busy=%b vec=%0d err=%0d want 1 1 0 5 0",
                               if_a.done, if_a.pass, if_a.busy, if_a.vec_count, if_a.err_count);
        end
    endtask

    task automatic test_first_err();
        logic [31:0] av [5] = '{32'h0, 32'hffffffff, 32'h0, 32'hffffffff, 32'hffffffff};
        logic [31:0] bv [5] = '{32'h0, 32'hffffffff, 32'hffffffff, 32'hffff0000, 32'h0000ffff};
        logic [31:0] zv [5] = '{32'h0, 32'hffffffff, 32'h1, 32'hffff0000, 32'h0000ffff};
        start_a();
        for (int i = 0; i < 5; i++) send_a(OP_AND, av[i], bv[i], zv[i], (i == 4));
        repeat (4) @(negedge clock);
        n_tests++;
        if ({if_a.done, if_a.pass, if_a.vec_count, if_a.err_count, if_a.first_err_idx} !==
            {2'b10, 16'd5, 16'd1, 16'd2}) begin
            n_fail++; $display("FAIL err_counts got done=%b pass=%b vec=%0d err=%0d idx=%0d want 1 0 5 1 2",
                               if_a.done, if_a.pass, if_a.vec_count, if_a.err_count, if_a.first_err_idx);
        end
        n_tests++;
        if ({if_a.first_err_exp, if_a.first_err_got} !== {32'h0, 32'h1}) begin
            n_fail++; $display("FAIL err_values got exp=%h got=%h want 00000000 00000001",
                               if_a.first_err_exp, if_a.first_err_got);
        end
    endtask

    task automatic test_ops();
        logic [3:0]  ov [14] = '{OP_ADD, OP_SHRA, OP_ROR, OP_SUB, OP_NOT, OP_NEG, OP_SHL,
                                 OP_SHR, OP_SHRA, OP_ROL, OP_ROL, OP_OR, OP_ROR, 4'd13};
        logic [31:0] av [14] = '{32'hffffffff, 32'h80000000, 32'h00000001, 32'h00000000,
                                 32'h0f0f0f0f, 32'h00000005, 32'h00000001, 32'h80000000,
                                 32'h7fffffff, 32'h80000001, 32'h12345678, 32'ha0a0a0a0,
                                 32'h12345678, 32'h00000000};
        logic [31:0] bv [14] = '{32'h00000001, 32'h00000004, 32'h00000001, 32'h00000001,
                                 32'h00000000, 32'h00000000, 32'h0000003f, 32'h0000001f,
                                 32'h00000004, 32'h00000004, 32'h00000020, 32'h05050505,
                                 32'h00000008, 32'h00000000};
        logic [31:0] zv [14] = '{32'h00000000, 32'hf8000000, 32'h80000000, 32'hffffffff,
                                 32'hf0f0f0f0, 32'hfffffffb, 32'h80000000, 32'h00000001,
                                 32'h07ffffff, 32'h00000018, 32'h12345678, 32'ha5a5a5a5,
                                 32'h78123456, 32'h12345678};
        start_a();
        n_tests++;
        if ({if_a.done, if_a.pass, if_a.err_count, if_a.vec_count, if_a.first_err_idx,
             if_a.first_err_got} !== 82'd0) begin
            n_fail++; $display("FAIL ops_start_clear got err=%0d vec=%0d idx=%0d got=%h want all 0",
                               if_a.err_count, if_a.vec_count, if_a.first_err_idx, if_a.first_err_got);
        end
        for (int i = 0; i < 14; i++) send_a(ov[i], av[i], bv[i], zv[i], (i == 13));
        repeat (4) @(negedge clock);
        n_tests++;
        if ({if_a.done, if_a.pass, if_a.vec_count, if_a.err_count, if_a.first_err_idx} !==
            {2'b10, 16'd14, 16'd1, 16'd13}) begin
            n_fail++; $display("FAIL ops_counts got done=%b pass=%b vec=%0d err=%0d idx=%0d want 1 0 14 1 13",
                               if_a.done, if_a.pass, if_a.vec_count, if_a.err_count, if_a.first_err_idx);
        end
        n_tests++;
        if ({if_a.first_err_exp, if_a.first_err_got} !== {32'h0, 32'h12345678}) begin
            n_fail++; $display("FAIL ops_illegal got exp=%h got=%h want 00000000 12345678",
                               if_a.first_err_exp, if_a.first_err_got);
        end
    endtask

    task automatic test_empty();
        start_a();
        if_a.vec_last = 1'b1;
        @(negedge clock);
        if_a.vec_last = 1'b0;
        send_a(OP_AND, 32'hffffffff, 32'hffffffff, 32'h0, 1'b0);
        send_a(OP_AND, 32'hffffffff, 32'hffffffff, 32'h0, 1'b0);
        @(negedge clock);
        n_tests++;
        if (if_a.done !== 1'b0) begin
            n_fail++; $display("FAIL empty_latency3 got done=%b want 0", if_a.done);
        end
        @(negedge clock);
        n_tests++;
        if ({if_a.done, if_a.pass, if_a.vec_count, if_a.err_count} !== {2'b10, 32'd0}) begin
            n_fail++; $display("FAIL empty_report got done=%b pass=%b vec=%0d err=%0d want 1 0 0 0",
                               if_a.done, if_a.pass, if_a.vec_count, if_a.err_count);
        end
        send_a(OP_AND, 32'hffffffff, 32'hffffffff, 32'h0, 1'b0);
        repeat (3) @(negedge clock);
        n_tests++;
        if ({if_a.done, if_a.vec_count} !== {1'b1, 16'd0}) begin
            n_fail++; $display("FAIL report_ignores got done=%b vec=%0d want 1 0", if_a.done, if_a.vec_count);
        end
    endtask

    task automatic test_clear_mid();
        start_a();
        send_a(OP_ADD, 32'h1, 32'h1, 32'h2, 1'b0);
        send_a(OP_ADD, 32'h2, 32'h2, 32'h5, 1'b0);
        if_a.vec_valid = 1'b1;
        clear = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        if_a.vec_valid = 1'b0;
        n_tests++;
        if ({if_a.busy, if_a.done, if_a.pass, if_a.err_count, if_a.vec_count, if_a.first_err_idx,
             if_a.first_err_exp, if_a.first_err_got} !== 115'd0) begin
            n_fail++; $display("FAIL clear_mid got busy=%b done=%b err=%0d vec=%0d want all 0",
                               if_a.busy, if_a.done, if_a.err_count, if_a.vec_count);
        end
        send_a(OP_AND, 32'h1, 32'h1, 32'h0, 1'b1);
        repeat (4) @(negedge clock);
        n_tests++;
        if ({if_a.busy, if_a.done, if_a.err_count, if_a.vec_count} !== 34'd0) begin
            n_fail++; $display("FAIL clear_idle got busy=%b done=%b err=%0d vec=%0d want 0 0 0 0",
                               if_a.busy, if_a.done, if_a.err_count, if_a.vec_count);
        end
    endtask

    task automatic test_start_drain();
        start_a();
        send_a(OP_AND, 32'hffffffff, 32'hffffffff, 32'hffffffff, 1'b1);
        @(negedge clock);
        n_tests++;
        if ({if_a.busy, if_a.done} !== 2'b10) begin
            n_fail++; $display("FAIL drain_busy got busy=%b done=%b want 1 0", if_a.busy, if_a.done);
        end
        start_a();
        n_tests++;
        if ({if_a.busy, if_a.vec_count, if_a.err_count} !== {1'b1, 32'd0}) begin
            n_fail++; $display("FAIL drain_restart got busy=%b vec=%0d err=%0d want 1 0 0",
                               if_a.busy, if_a.vec_count, if_a.err_count);
        end
        repeat (4) @(negedge clock);
        n_tests++;
        if ({if_a.busy, if_a.done, if_a.vec_count} !== {2'b10, 16'd0}) begin
            n_fail++; $display("FAIL drain_flushed got busy=%b done=%b vec=%0d want 1 0 0",
                               if_a.busy, if_a.done, if_a.vec_count);
        end
        send_a(OP_OR, 32'h0000f000, 32'h0000000f, 32'h0000f00e, 1'b1);
        repeat (4) @(negedge clock);
        n_tests++;
        if ({if_a.done, if_a.vec_count, if_a.err_count, if_a.first_err_idx, if_a.first_err_exp} !==
            {1'b1, 16'd1, 16'd1, 16'd0, 32'h0000f00f}) begin
            n_fail++; $display("FAIL restart_session got done=%b vec=%0d err=%0d idx=%0d exp=%h want 1 1 1 0 0000f00f",
                               if_a.done, if_a.vec_count, if_a.err_count, if_a.first_err_idx, if_a.first_err_exp);
        end
    endtask

    task automatic test_saturation();
        if_s.start = 1'b1;
        @(negedge clock);
        if_s.start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if_s.op = 4'd13; if_s.Ra = 32'd0; if_s.Rb = 32'd0; if_s.Rz = 32'h100 + 32'(i);
            if_s.vec_valid = 1'b1; if_s.vec_last = (i == 8);
            @(negedge clock);
        end
        if_s.vec_valid = 1'b0; if_s.vec_last = 1'b0;
        repeat (4) @(negedge clock);
        n_tests++;
        if ({if_s.done, if_s.pass, if_s.err_count, if_s.vec_count, if_s.first_err_idx} !==
            {2'b10, 3'd7, 3'd7, 3'd0}) begin
            n_fail++; $display("FAIL sat_counts got done=%b pass=%b err=%0d vec=%0d idx=%0d want 1 0 7 7 0",
                               if_s.done, if_s.pass, if_s.err_count, if_s.vec_count, if_s.first_err_idx);
        end
        n_tests++;
        if ({if_s.first_err_exp, if_s.first_err_got} !== {32'h0, 32'h100}) begin
            n_fail++; $display("FAIL sat_first got exp=%h got=%h want 00000000 00000100",
                               if_s.first_err_exp, if_s.first_err_got);
        end
    endtask

    initial begin
        idle_all();
        clear = 1'b0;
        test_reset();
        test_and_pass();
        test_first_err();
        test_ops();
        test_empty();
        test_clear_mid();
        test_start_drain();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
